// File: rtl/noise_gate_pkg.sv
// -----------------------------------------------------------------------------
// noise_gate_pkg
// Shared types and constants for the noise gate dynamics stage.
//   SAMPLE_W     : audio sample width (signed)
//   GAIN_W       : gain register width; gain range is 0..GAIN_UNITY
//   GAIN_UNITY   : gain code for 0 dB (output == input)
//   gate_state_t : gate state machine states
// -----------------------------------------------------------------------------
package noise_gate_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 9;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } gate_state_t;

endpackage : noise_gate_pkg

// File: rtl/noise_gate_envelope.sv
// -----------------------------------------------------------------------------
// envelope_follower
// Peak envelope detector with exponential decay. The envelope jumps to
// |sampleIn| instantly and otherwise decays by env >> ENV_SHIFT each sample.
//
// Parameters:
//   ENV_SHIFT : decay shift, 1..15
// Ports:
//   clk      in  1   sample clock
//   reset    in  1   synchronous, active-high
//   sampleIn in  16  signed input sample
//   envOut   out 16  registered unsigned envelope
// -----------------------------------------------------------------------------
module envelope_follower
  import noise_gate_pkg::*;
#(
  parameter int ENV_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sampleIn,
  output logic        [SAMPLE_W-1:0] envOut
);

  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] abs_val;
  logic [SAMPLE_W-1:0] decayed;
  logic [SAMPLE_W-1:0] env_d;
  logic [SAMPLE_W-1:0] env_q;

  // NOTE: every signal written in always_comb gets a value on every path
  // (here via the if/else chain and unconditional assigns) so no latch is
  // inferred.
  always_comb begin
    // The most negative sample has no positive twin in 16 bits; clamp it.
    if (sampleIn == SAMPLE_MIN) begin
      abs_val = SAMPLE_MAX;
    end else if (sampleIn[SAMPLE_W-1]) begin
      abs_val = SAMPLE_W'(-sampleIn);
    end else begin
      abs_val = SAMPLE_W'(sampleIn);
    end
    decayed = env_q - (env_q >> ENV_SHIFT);
    env_d   = (abs_val > decayed) ? abs_val : decayed;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      env_q <= '0;
    end else begin
      env_q <= env_d;
    end
  end

  assign envOut = env_q;

endmodule : envelope_follower

// File: rtl/noise_gate.sv
// -----------------------------------------------------------------------------
// noise_gate
// Dynamics stage: an envelope follower drives a CLOSED/ATTACK/OPEN/HOLD/RELEASE
// state machine that ramps a 9-bit gain (256 = unity) applied to the one-sample
// delayed input, muting sub-threshold signal without clicks.
//
// Build option:
//   NOISE_GATE_HOLD_EN : when defined, a HOLD state keeps unity gain for
//                        HOLD_SAMPLES samples before releasing; when undefined
//                        OPEN releases directly and HOLD_SAMPLES is ignored.
//
// Ports:
//   clk      in  1   sample clock, rising edge
//   reset    in  1   synchronous, active-high
//   gateIn   in  16  signed sample
//   gateOut  out 16  registered gated sample, (xReg * gain) >>> 8
//   gainOut  out 9   registered gain, 0..256
//   gateOpen out 1   registered, high whenever state != CLOSED
// -----------------------------------------------------------------------------
module noise_gate
  import noise_gate_pkg::*;
#(
  parameter int THRESH_OPEN  = 2048,
  parameter int THRESH_CLOSE = 1024,
  parameter int HOLD_SAMPLES = 240,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 1,
  parameter int ENV_SHIFT    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] gateIn,
  output logic signed [SAMPLE_W-1:0] gateOut,
  output logic        [GAIN_W-1:0]   gainOut,
  output logic                       gateOpen
);

  // Elaboration-time guard against an inconsistent parameter set.
  if (THRESH_CLOSE > THRESH_OPEN || HOLD_SAMPLES < 1 ||
      ATTACK_STEP < 1 || ATTACK_STEP > 256 ||
      RELEASE_STEP < 1 || RELEASE_STEP > 256 ||
      ENV_SHIFT < 1 || ENV_SHIFT > 15) begin : g_bad_cfg
    $error("noise_gate: invalid parameter set");
  end

  localparam int PROD_W = SAMPLE_W + GAIN_W;

  localparam logic [SAMPLE_W-1:0] OPEN_LVL  = SAMPLE_W'(THRESH_OPEN);
  localparam logic [SAMPLE_W-1:0] CLOSE_LVL = SAMPLE_W'(THRESH_CLOSE);
  localparam logic [GAIN_W:0]     ATK_INC   = (GAIN_W+1)'(ATTACK_STEP);
  localparam logic [GAIN_W-1:0]   REL_DEC   = GAIN_W'(RELEASE_STEP);

`ifdef NOISE_GATE_HOLD_EN
  localparam int HCNT_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_SAMPLES - 1);

  logic [HCNT_W-1:0] hold_cnt_q;
`endif

  logic [SAMPLE_W-1:0] env;

  gate_state_t                state_q;
  logic        [GAIN_W-1:0]   gain_q;
  logic                       open_q;
  logic signed [SAMPLE_W-1:0] x_q;
  logic signed [SAMPLE_W-1:0] gate_out_q;

  logic                       env_open;
  logic                       env_low;
  logic        [GAIN_W:0]     gain_sum;
  logic        [GAIN_W-1:0]   gain_up;
  logic        [GAIN_W-1:0]   gain_dn;
  gate_state_t                atk_state;
  gate_state_t                rel_state;
  logic signed [PROD_W-1:0]   product;
  logic signed [SAMPLE_W-1:0] gate_out_d;

  envelope_follower #(
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk      (clk),
    .reset    (reset),
    .sampleIn (gateIn),
    .envOut   (env)
  );

  // Ramp arithmetic and the state each ramp lands in. The ramp step is applied
  // on the same edge that enters ATTACK/RELEASE, so gateOpen rises together
  // with the first nonzero gain and a retrigger continues from the current
  // gain without a dip.
  always_comb begin
    env_open  = (env >= OPEN_LVL);
    env_low   = (env < CLOSE_LVL);
    gain_sum  = {1'b0, gain_q} + ATK_INC;
    gain_up   = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[GAIN_W-1:0];
    gain_dn   = (gain_q > REL_DEC) ? (gain_q - REL_DEC) : '0;
    atk_state = (gain_up == GAIN_UNITY) ? OPEN : ATTACK;
    rel_state = (gain_dn == '0) ? CLOSED : RELEASE;
    // The gain is zero-extended, so the sign of the product is the sample's;
    // the arithmetic shift floors toward -inf and unity gain is bit-exact.
    product    = PROD_W'(x_q) * PROD_W'($signed({1'b0, gain_q}));
    gate_out_d = SAMPLE_W'(product >>> 8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLOSED;
      gain_q     <= '0;
      open_q     <= 1'b0;
      x_q        <= '0;
      gate_out_q <= '0;
`ifdef NOISE_GATE_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      x_q        <= gateIn;
      gate_out_q <= gate_out_d;

      case (state_q)
        CLOSED: begin
          gain_q <= '0;
          if (env_open) begin
            state_q <= atk_state;
            gain_q  <= gain_up;
            open_q  <= 1'b1;
          end
        end

        ATTACK: begin
          state_q <= atk_state;
          gain_q  <= gain_up;
        end

        OPEN: begin
          gain_q <= GAIN_UNITY;
          if (env_low) begin
`ifdef NOISE_GATE_HOLD_EN
            state_q    <= HOLD;
            hold_cnt_q <= '0;
`else
            state_q <= rel_state;
            gain_q  <= gain_dn;
            open_q  <= (gain_dn != '0);
`endif
          end
        end

`ifdef NOISE_GATE_HOLD_EN
        HOLD: begin
          gain_q <= GAIN_UNITY;
          if (env_open) begin
            state_q <= OPEN;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= rel_state;
            gain_q  <= gain_dn;
            open_q  <= (gain_dn != '0);
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
`endif

        RELEASE: begin
          if (env_open) begin
            state_q <= atk_state;
            gain_q  <= gain_up;
          end else begin
            state_q <= rel_state;
            gain_q  <= gain_dn;
            open_q  <= (gain_dn != '0);
          end
        end

        default: begin
          state_q <= CLOSED;
          gain_q  <= '0;
          open_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gateOut  = gate_out_q;
  assign gainOut  = gain_q;
  assign gateOpen = open_q;

endmodule : noise_gate

// File: tb/tb_noise_gate.sv
// -----------------------------------------------------------------------------
// tb_noise_gate
// Self-checking bench for noise_gate. A behavioural model of the gate rules
// (integer arithmetic, one step per sample) runs in lockstep with the DUT;
// directed scenarios add fixed expected values for the key behaviours.
// -----------------------------------------------------------------------------
module tb_noise_gate;

  localparam int THRESH_OPEN  = 2048;
  localparam int THRESH_CLOSE = 1024;
  localparam int HOLD_SAMPLES = 240;
  localparam int ATTACK_STEP  = 64;
  localparam int RELEASE_STEP = 1;
  localparam int ENV_SHIFT    = 4;

`ifdef NOISE_GATE_HOLD_EN
  localparam int PLATEAU = HOLD_SAMPLES;
`else
  localparam int PLATEAU = 0;
`endif

  localparam int M_CLOSED  = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_OPEN    = 2;
  localparam int M_HOLD    = 3;
  localparam int M_RELEASE = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] gateIn;
  logic signed [15:0] gateOut;
  logic        [8:0]  gainOut;
  logic               gateOpen;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_env, m_x, m_gain, m_state, m_cnt, m_out;

  noise_gate #(
    .THRESH_OPEN  (THRESH_OPEN),
    .THRESH_CLOSE (THRESH_CLOSE),
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .ATTACK_STEP  (ATTACK_STEP),
    .RELEASE_STEP (RELEASE_STEP),
    .ENV_SHIFT    (ENV_SHIFT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .gateIn   (gateIn),
    .gateOut  (gateOut),
    .gainOut  (gainOut),
    .gateOpen (gateOpen)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic ramp_up();
    m_gain  = (m_gain + ATTACK_STEP > 256) ? 256 : m_gain + ATTACK_STEP;
    m_state = (m_gain == 256) ? M_OPEN : M_ATTACK;
  endtask

  task automatic ramp_down();
    m_gain  = (m_gain - RELEASE_STEP < 0) ? 0 : m_gain - RELEASE_STEP;
    m_state = (m_gain == 0) ? M_CLOSED : M_RELEASE;
  endtask

  task automatic model_step(input int s, input bit rst);
    int a, dec;
    if (rst) begin
      m_env = 0; m_x = 0; m_gain = 0; m_state = M_CLOSED; m_cnt = 0; m_out = 0;
    end else begin
      // Output uses the delayed sample and the gain before this sample's update.
      m_out = (m_x * m_gain) >>> 8;
      case (m_state)
        M_CLOSED:  if (m_env >= THRESH_OPEN) ramp_up();
        M_ATTACK:  ramp_up();
        M_OPEN: begin
          m_gain = 256;
          if (m_env < THRESH_CLOSE) begin
            if (PLATEAU > 0) begin m_state = M_HOLD; m_cnt = 0; end
            else ramp_down();
          end
        end
        M_HOLD: begin
          if (m_env >= THRESH_OPEN) m_state = M_OPEN;
          else if (m_cnt == HOLD_SAMPLES - 1) ramp_down();
          else m_cnt++;
        end
        default: begin
          if (m_env >= THRESH_OPEN) ramp_up();
          else ramp_down();
        end
      endcase
      m_x = s;
      a   = (s < 0) ? ((s == -32768) ? 32767 : -s) : s;
      dec = m_env - (m_env >> ENV_SHIFT);
      m_env = (a > dec) ? a : dec;
    end
  endtask

  // Drive one sample, let the edge happen, advance the model, settle.
  task automatic tick(input int s, input bit rst);
    gateIn = 16'(s);
    reset  = rst;
    @(posedge clk);
    model_step(s, rst);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(7094, 1'b1);
      checks++;
      if (gateOut !== 16'sd0 || gainOut !== 9'd0 || gateOpen !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: out=%0d gain=%0d open=%0b, want 0/0/0",
                 i, gateOut, gainOut, gateOpen);
      end
    end
  endtask

  task automatic test_silence();
    for (int i = 0; i < 1000; i++) begin
      tick(100, 1'b0);
      checks++;
      if (gateOut !== 16'sd0 || gainOut !== 9'd0 || gateOpen !== 1'b0) begin
        errors++;
        $display("FAIL silence[%0d]: out=%0d gain=%0d open=%0b, want 0/0/0",
                 i, gateOut, gainOut, gateOpen);
      end
    end
  endtask

  task automatic test_open();
    int exp_g[10] = '{0, 64, 128, 192, 256, 256, 256, 256, 256, 256};
    for (int i = 0; i < 3; i++) tick(0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(7094, 1'b0);
      checks++;
      if (gainOut !== 9'(exp_g[k]) || gateOpen !== (k >= 1)) begin
        errors++;
        $display("FAIL open_ramp[%0d]: gain=%0d open=%0b, want gain=%0d open=%0b",
                 k, gainOut, gateOpen, exp_g[k], (k >= 1));
      end
      checks++;
      if (gateOut !== 16'(m_out)) begin
        errors++;
        $display("FAIL open_out[%0d]: out=%0d, want %0d", k, gateOut, m_out);
      end
      if (k >= 5) begin
        checks++;
        if (gateOut !== 16'sd7094) begin
          errors++;
          $display("FAIL open_settle[%0d]: out=%0d, want 7094", k, gateOut);
        end
      end
    end
  endtask

  task automatic test_close();
    int e, d, first_drop, closed_at, exp_drop, exp_closed;
    e = m_env;
    d = 0;
    while (e >= THRESH_CLOSE) begin
      e = e - (e >> ENV_SHIFT);
      d++;
    end
    exp_drop   = d + 1 + PLATEAU;
    exp_closed = exp_drop + (256 + RELEASE_STEP - 1) / RELEASE_STEP - 1;
    first_drop = 0;
    closed_at  = 0;
    for (int k = 1; k <= 1200; k++) begin
      tick(0, 1'b0);
      if (k == d) begin
        checks++;
        if (dut.u_env.envOut !== 16'(e)) begin
          errors++;
          $display("FAIL close_env: env=%0d after %0d samples, want %0d",
                   dut.u_env.envOut, d, e);
        end
      end
      checks++;
      if (gateOut !== 16'(m_out) || gainOut !== 9'(m_gain) || gateOpen !== (m_state != M_CLOSED)) begin
        errors++;
        $display("FAIL close[%0d]: out=%0d gain=%0d open=%0b, want %0d/%0d/%0b",
                 k, gateOut, gainOut, gateOpen, m_out, m_gain, (m_state != M_CLOSED));
      end
      if (first_drop == 0 && gainOut < 9'd256) first_drop = k;
      if (closed_at == 0 && gateOpen === 1'b0) closed_at = k;
    end
    checks++;
    if (first_drop != exp_drop) begin
      errors++;
      $display("FAIL close_plateau: gain left unity at sample %0d, want %0d", first_drop, exp_drop);
    end
    checks++;
    if (closed_at != exp_closed) begin
      errors++;
      $display("FAIL close_closed: gate closed at sample %0d, want %0d", closed_at, exp_closed);
    end
  endtask

  task automatic test_retrigger();
    int seen;
    int exp_g[3] = '{128, 192, 256};
    for (int i = 0; i < 8; i++) tick(7094, 1'b0);
    seen = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      tick(0, 1'b0);
      if (gainOut === 9'd129) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL retrig_wait: gain never reached 129 (last %0d)", gainOut);
    end
    for (int k = 0; k < 3; k++) begin
      tick(7094, 1'b0);
      checks++;
      if (gainOut !== 9'(exp_g[k]) || gateOpen !== 1'b1) begin
        errors++;
        $display("FAIL retrig[%0d]: gain=%0d open=%0b, want gain=%0d open=1",
                 k, gainOut, gateOpen, exp_g[k]);
      end
    end
  endtask

  task automatic test_extremes();
    int seq[3] = '{0, 7094, -7094};
    tick(-32768, 1'b0);
    checks++;
    if (dut.u_env.envOut !== 16'd32767) begin
      errors++;
      $display("FAIL extreme_env: env=%0d, want 32767", dut.u_env.envOut);
    end
    tick(0, 1'b0);
    checks++;
    if (gateOut !== -16'sd32768) begin
      errors++;
      $display("FAIL extreme_out: out=%0d, want -32768", gateOut);
    end
    for (int i = 0; i < 300; i++) begin
      tick(seq[i % 3], 1'b0);
      checks++;
      if (gateOpen !== 1'b1 || gainOut !== 9'd256 || gateOut !== 16'(m_out)) begin
        errors++;
        $display("FAIL alternating[%0d]: out=%0d gain=%0d open=%0b, want %0d/256/1",
                 i, gateOut, gainOut, gateOpen, m_out);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int exp_g[7] = '{0, 64, 128, 0, 0, 0, 64};
    int exp_o[7] = '{0, 0, 0, 0, 0, 0, 0};
    bit rst_v[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int smp[7]   = '{7094, 7094, 7094, 7094, 0, 7094, 7094};
    tick(0, 1'b1);
    for (int i = 0; i < 3; i++) tick(0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick(smp[k], rst_v[k]);
      checks++;
      if (gainOut !== 9'(exp_g[k]) || (k >= 3 && k <= 5 && gateOut !== 16'(exp_o[k]))) begin
        errors++;
        $display("FAIL reset_mid[%0d]: gain=%0d out=%0d, want gain=%0d",
                 k, gainOut, gateOut, exp_g[k]);
      end
    end
  endtask

  task automatic test_random();
    int kind, len, s, amp;
    bit rst;
    tick(0, 1'b1);
    for (int n = 0; n < 6000; ) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 400));
      for (int j = 0; j < len && n < 6000; j++, n++) begin
        case (kind)
          0: s = int'($urandom_range(0, 1800)) - 900;
          1: s = int'($urandom_range(0, 65535)) - 32768;
          default: begin
            amp = int'($urandom_range(1024, 2047));
            s   = ($urandom_range(0, 1) == 1) ? amp : -amp;
          end
        endcase
        rst = ($urandom_range(0, 499) == 0);
        tick(s, rst);
        checks++;
        if (gateOut !== 16'(m_out) || gainOut !== 9'(m_gain) || gateOpen !== (m_state != M_CLOSED)) begin
          errors++;
          $display("FAIL random[%0d]: in=%0d out=%0d gain=%0d open=%0b, want %0d/%0d/%0b",
                   n, s, gateOut, gainOut, gateOpen, m_out, m_gain, (m_state != M_CLOSED));
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    gateIn = '0;
    m_env = 0; m_x = 0; m_gain = 0; m_state = M_CLOSED; m_cnt = 0; m_out = 0;

    test_reset();
    test_silence();
    test_open();
    test_close();
    test_retrigger();
    test_extremes();
    test_reset_mid_ramp();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_noise_gate

// File: doc/noise_gate.md
# noise_gate

Downstream dynamics stage of the channel strip: consumes the 16-bit signed output of the lowpass filter, one sample per `clk` (sample-rate clock). A peak envelope follower drives an open/hold/release state machine. The state machine ramps a 9-bit gain applied to the delayed signal, so that signal below threshold is muted without clicks. The gated output feeds the output stage.

## Interface
- `THRESH_OPEN`, 2048: envelope level at or above which the gate opens.
- `THRESH_CLOSE`, 1024: envelope level below which the gate starts closing; must be ≤ `THRESH_OPEN`.
- `HOLD_SAMPLES`, 240: samples the gate stays at unity after the envelope drops below `THRESH_CLOSE`; must be ≥ 1.
- `ATTACK_STEP`, 64: gain increment per sample while opening; 1..256.
- `RELEASE_STEP`, 1: gain decrement per sample while closing; 1..256.
- `ENV_SHIFT`, 4: envelope decay shift; 1..15.
- `clk` in 1: sample clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `gateIn` in 16: signed sample from the lowpass filter.
- `gateOut` out 16: signed gated sample; registered.
- `gainOut` out 9: current gain, 0..256, where 256 = unity; registered.
- `gateOpen` out 1: high whenever state ≠ CLOSED; registered.

## Operation
- Absolute value: `|gateIn|`, with -32768 saturated to 32767. The result is 16-bit unsigned.
- Envelope update: `env <= max(abs, env - (env >> ENV_SHIFT))`. `env` is 16-bit unsigned.
- States, with all tests on the registered `env`:
  - CLOSED: gain = 0. If env ≥ `THRESH_OPEN`, go to ATTACK.
  - ATTACK: gain += `ATTACK_STEP`, saturating at 256. When the updated gain is 256, go to OPEN. Env is ignored while ramping up.
  - OPEN: gain = 256. If env < `THRESH_CLOSE`, go to HOLD and clear the hold counter.
  - HOLD: gain = 256; the counter increments each sample.
    - If env ≥ `THRESH_OPEN`, go to OPEN.
    - Otherwise, when the counter reaches `HOLD_SAMPLES`-1, go to RELEASE.
  - RELEASE: gain -= `RELEASE_STEP`, floored at 0.
    - If env ≥ `THRESH_OPEN`, go to ATTACK and ramp up from the current gain. This check takes priority.
    - Otherwise, when the updated gain is 0, go to CLOSED.
- Hysteresis: env values between `THRESH_CLOSE` and `THRESH_OPEN` cause no transition in any state.
- Gain arithmetic: signed 16-bit × zero-extended 9-bit gives a 25-bit product.
  - The product is shifted arithmetically right by 8 (truncates toward −∞).
  - No saturation is needed. At gain = 256 the output equals the input bit-exactly, including -32768.
- Reset: `gateOut` = 0, `gainOut` = 0, `gateOpen` = 0; internally env = 0, delayed sample = 0, state CLOSED, hold counter 0. Reset asserted mid-ramp or mid-hold takes effect on the next edge with no residual state.

## Timing
- Edge n:
  - `xReg <= gateIn` and `env` is updated from `gateIn`.
  - The state and gain update using the env value registered at edge n-1.
  - `gateOut <= (xReg * gain) >>> 8`, using the gain value before this edge's update.
- Signal latency: `gateIn` at edge n appears on `gateOut` at edge n+1.
- Control latency: a step on `gateIn` shows in env after 1 edge, in state after 2 edges, and in `gateOut` scaling after 3 edges.
- `gainOut` and `gateOpen` reflect the state and gain registers directly, with no extra delay.
- Throughput: one sample per clock, with no stalls and no handshake.

## Configuration
- `NOISE_GATE_HOLD_EN` defined: the HOLD state and its hold counter exist exactly as above.
- Not defined: no HOLD state and no counter; OPEN goes directly to RELEASE when env < `THRESH_CLOSE`. `HOLD_SAMPLES` is accepted but ignored.

## Structure
- `noise_gate_pkg`: state enum `gate_state_t` (CLOSED, ATTACK, OPEN, HOLD, RELEASE), `GAIN_W` = 9, `GAIN_UNITY` = 9'd256, `SAMPLE_W` = 16.
- Sub-module `envelope_follower`: contains the abs/saturate logic and the peak-with-decay register. It has parameter `ENV_SHIFT`, ports `clk`, `reset`, `sampleIn`, and `envOut`.
- The top module holds the state machine, gain ramp, hold counter and multiplier.

## Test plan
- Reset: drive `gateIn`=7094 while `reset`=1 for 5 cycles → `gateOut`=0, `gainOut`=0, `gateOpen`=0 throughout.
- Silence: `gateIn`=100 for 1000 cycles → state stays CLOSED, `gainOut`=0, `gateOut`=0.
- Open: `gateIn` steps from 0 to 7094 →
  - `gainOut` goes 64, 128, 192, 256 on consecutive edges starting 2 edges after the step;
  - `gateOpen` asserts with the first ramp step;
  - `gateOut` settles at exactly 7094.
- Close with hold: from OPEN, `gateIn`=0 →
  - env decays by `env>>4` per sample until < 1024;
  - gain then stays 256 for 240 cycles;
  - gain then falls by 1 per cycle to 0 over 256 cycles;
  - `gateOpen` drops when CLOSED is entered.
  - Without `NOISE_GATE_HOLD_EN`: same, but with no 240-cycle plateau.
- Retrigger: in RELEASE at `gainOut`=128, apply `gateIn`=7094 → state goes to ATTACK, gain goes 192 then 256, with no dip to 0.
- Extremes at unity gain: `gateIn`=-32768 → `gateOut`=-32768 one edge later and env=32767. The alternating sequence 0, 7094, -7094 keeps the gate OPEN indefinitely.
